thiele_exec_core: RTL and testbench

//  Synthesizable, parametrised execution engine for the Thiele simple ISA (PNEW/PMERGE/XOR_*/EMIT/HALT).
//  It fetches 32-bit instructions over a req/valid port and keeps a module partition table, data memory and mu counters.
//  On HALT it computes the 256-bit state hash on-chip, one word per cycle.
//  It replaces the simulation-only fuzz flow on FPGA and Verilator builds; hashes must match the Python VM bit-exactly.

---
 rtl/thiele_isa_pkg.sv | 32 +++
 rtl/thiele_module_table.sv | 68 ++++++
 rtl/thiele_exec_core.sv | 194 +++++++++++++++++++
 tb/tb_thiele_exec_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thiele_isa_pkg.sv
// Shared Thiele ISA constants, core FSM encoding and the xorshift word mixer.
// Opcode values and the mixer must stay bit-identical to the Python VM.
package thiele_isa_pkg;

  localparam logic [7:0] OP_PNEW     = 8'h00;
  localparam logic [7:0] OP_PSPLIT   = 8'h01;
  localparam logic [7:0] OP_PMERGE   = 8'h02;
  localparam logic [7:0] OP_XOR_LOAD = 8'h0A;
  localparam logic [7:0] OP_XOR_ADD  = 8'h0B;
  localparam logic [7:0] OP_XOR_SWAP = 8'h0C;
  localparam logic [7:0] OP_EMIT     = 8'h0E;
  localparam logic [7:0] OP_HALT     = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_EMIT_WAIT = 3'd3,
    ST_HASH      = 3'd4,
    ST_DONE      = 3'd5
  } core_state_e;

  function automatic logic [31:0] xorshift_mix32(input logic [31:0] w);
    logic [31:0] x;
    x = w;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

endpackage

// File: rtl/thiele_module_table.sv
// Partition module table: PNEW appends an entry, PMERGE folds entry b into entry a.
// Exposes the low 32 bits of masks 0 and 1 for the state hash.
module thiele_module_table
  import thiele_isa_pkg::*;
#(
  parameter int MAX_MODULES = 64,
  parameter int MASK_W      = 64,
  localparam int CNT_W      = $clog2(MAX_MODULES + 1),
  localparam int IDX_W      = $clog2(MAX_MODULES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             pnew_en,
  input  logic             pmerge_en,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             disc_inc,
  output logic             merge_ok,
  output logic [CNT_W-1:0] num_modules,
  output logic [31:0]      next_id,
  output logic [31:0]      mask0_lo,
  output logic [31:0]      mask1_lo
);

  logic [MASK_W-1:0]      mask [MAX_MODULES];
  logic [MAX_MODULES-1:0] valid;
  logic [IDX_W-1:0]       idx_a, idx_b, idx_new;
  logic                   pnew_ok, a_in_mask;
  logic [MASK_W-1:0]      new_mask;

  assign idx_a     = IDX_W'(op_a);
  assign idx_b     = IDX_W'(op_b);
  assign idx_new   = IDX_W'(num_modules);
  assign a_in_mask = {24'd0, op_a} < 32'(MASK_W);
  assign new_mask  = a_in_mask ? (MASK_W'(1) << op_a) : '0;

  // A full table swallows PNEW silently; an out-of-range region still takes a slot.
  assign pnew_ok  = pnew_en && (32'(num_modules) < 32'(MAX_MODULES));
  assign disc_inc = pnew_ok && a_in_mask;
  assign merge_ok = pmerge_en && (op_a != op_b)
                  && ({24'd0, op_a} < 32'(num_modules))
                  && ({24'd0, op_b} < 32'(num_modules))
                  && valid[idx_a] && valid[idx_b];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      num_modules <= '0;
      next_id     <= '0;
      valid       <= '0;
      for (int i = 0; i < MAX_MODULES; i++) mask[i] <= '0;
    end else if (pnew_ok) begin
      mask[idx_new]  <= new_mask;
      valid[idx_new] <= 1'b1;
      next_id        <= next_id + 32'd1;
      num_modules    <= num_modules + CNT_W'(1);
    end else if (merge_ok) begin
      mask[idx_a]  <= mask[idx_a] | mask[idx_b];
      mask[idx_b]  <= '0;
      valid[idx_b] <= 1'b0;
      num_modules  <= num_modules - CNT_W'(1);
    end
  end

  assign mask0_lo = 32'(mask[0]);
  assign mask1_lo = 32'(mask[1]);

endmodule

// File: rtl/thiele_exec_core.sv
// Thiele simple-ISA execution core: fetch/exec FSM, data memory, mu counters,
// busy-cycle timeout and an 8-cycle on-chip state hash after HALT.
module thiele_exec_core
  import thiele_isa_pkg::*;
#(
  parameter int PC_W           = 8,
  parameter int DATA_W         = 32,
  parameter int DMEM_DEPTH     = 256,
  parameter int MAX_MODULES    = 64,
  parameter int MASK_W         = 64,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic            emit_valid,
  output logic [7:0]      emit_a,
  output logic [7:0]      emit_b,
  input  logic            emit_ready,
  output logic            busy,
  output logic            done,
  output logic            timed_out,
  output logic [255:0]    final_hash,
  output logic [63:0]     mu_total,
  output logic [31:0]     step_count,
  output logic [31:0]     pc
);

  localparam int AW    = $clog2(DMEM_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(MAX_MODULES + 1);

  core_state_e       state, state_next;
  logic [7:0]        ins_op, ins_a, ins_b;
  logic [63:0]       mu_disc, mu_exec;
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [TO_W-1:0]   busy_cnt;
  logic [2:0]        hash_idx;
  logic [1:0]        exec_mu;
  logic [31:0]       hash_word;
  logic              clear_all, busy_state, timeout_hit, exec_ok;
  logic              disc_inc, merge_ok;
  logic [CNT_W-1:0]  num_modules;
  logic [31:0]       next_id, mask0_lo, mask1_lo;
  logic [AW-1:0]     da, db;
  logic              rsvd_unused;

  assign rsvd_unused = ^imem_rdata[7:0];
  assign clear_all   = (state == ST_IDLE) && start;
  assign busy_state  = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_EMIT_WAIT);
  assign timeout_hit = busy_state && (busy_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign exec_ok     = (state == ST_EXEC) && !timeout_hit;
  assign da          = AW'(ins_a);
  assign db          = AW'(ins_b);

  thiele_module_table #(.MAX_MODULES(MAX_MODULES), .MASK_W(MASK_W)) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_all),
    .pnew_en     (exec_ok && (ins_op == OP_PNEW)),
    .pmerge_en   (exec_ok && (ins_op == OP_PMERGE)),
    .op_a        (ins_a),
    .op_b        (ins_b),
    .disc_inc    (disc_inc),
    .merge_ok    (merge_ok),
    .num_modules (num_modules),
    .next_id     (next_id),
    .mask0_lo    (mask0_lo),
    .mask1_lo    (mask1_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Handshakes: imem and emit transfers complete on a clock edge where both
  // valid (imem_valid / emit_valid) and the requester side (imem_req / emit_ready)
  // are high; the offering side holds its payload stable until then. Timeout wins.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_FETCH;
      ST_FETCH:     if (timeout_hit) state_next = ST_DONE;
                    else if (imem_valid) state_next = ST_EXEC;
      ST_EXEC:      if (timeout_hit) state_next = ST_DONE;
                    else if (ins_op == OP_EMIT) state_next = ST_EMIT_WAIT;
                    else if (ins_op == OP_HALT) state_next = ST_HASH;
                    else state_next = ST_FETCH;
      ST_EMIT_WAIT: if (timeout_hit) state_next = ST_DONE;
                    else if (emit_ready) state_next = ST_FETCH;
      ST_HASH:      if (hash_idx == 3'd7) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    exec_mu = 2'd0;
    case (ins_op)
      OP_PMERGE:                          exec_mu = {1'b0, merge_ok};
      OP_XOR_LOAD, OP_XOR_ADD, OP_HALT:   exec_mu = 2'd1;
      OP_XOR_SWAP:                        exec_mu = 2'd3;
      OP_PSPLIT, OP_EMIT:                 exec_mu = 2'd0;
      default:                            exec_mu = 2'd0;
    endcase
  end

  always_comb begin
    hash_word = 32'd0;
    case (hash_idx)
      3'd0: hash_word = pc ^ next_id;
      3'd1: hash_word = 32'(num_modules) ^ step_count;
      3'd2: hash_word = mu_disc[31:0] ^ mu_exec[31:0];
      3'd3: hash_word = mu_total[31:0];
      3'd4: hash_word = mask0_lo;
      3'd5: hash_word = mask1_lo;
      3'd6: hash_word = 32'(dmem[0]);
      3'd7: hash_word = 32'(dmem[1]);
      default: hash_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_all) begin
      ins_op     <= '0;
      ins_a      <= '0;
      ins_b      <= '0;
      pc         <= '0;
      step_count <= '0;
      mu_disc    <= '0;
      mu_exec    <= '0;
      busy_cnt   <= '0;
      hash_idx   <= '0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
      final_hash <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else begin
      if (busy_state) busy_cnt <= busy_cnt + TO_W'(1);
      case (state)
        ST_FETCH: if (imem_valid && !timeout_hit) begin
          ins_op <= imem_rdata[31:24];
          ins_a  <= imem_rdata[23:16];
          ins_b  <= imem_rdata[15:8];
        end
        ST_EXEC: if (!timeout_hit) begin
          if (ins_op != OP_HALT && ins_op != OP_EMIT) begin
            pc         <= pc + 32'd1;
            step_count <= step_count + 32'd1;
          end
          mu_disc <= mu_disc + 64'(disc_inc);
          mu_exec <= mu_exec + 64'(exec_mu);
          case (ins_op)
            OP_XOR_LOAD: dmem[da] <= DATA_W'(ins_b);
            OP_XOR_ADD:  dmem[da] <= dmem[da] ^ dmem[db];
            OP_XOR_SWAP: if (da == db) dmem[da] <= '0;
                         else begin
                           dmem[da] <= dmem[db];
                           dmem[db] <= dmem[da];
                         end
            default: ;
          endcase
        end
        ST_EMIT_WAIT: if (emit_ready && !timeout_hit) begin
          pc         <= pc + 32'd1;
          step_count <= step_count + 32'd1;
        end
        ST_HASH: begin
          final_hash[{hash_idx, 5'd0} +: 32] <= xorshift_mix32(hash_word);
          hash_idx <= hash_idx + 3'd1;
        end
        default: ;
      endcase
      if (state_next == ST_DONE) begin
        done      <= 1'b1;
        timed_out <= timeout_hit;
      end
    end
  end

  assign mu_total   = mu_disc + mu_exec;
  assign imem_req   = (state == ST_FETCH);
  assign imem_addr  = pc[PC_W-1:0];
  assign emit_valid = (state == ST_EMIT_WAIT);
  assign emit_a     = emit_valid ? ins_a : 8'h00;
  assign emit_b     = emit_valid ? ins_b : 8'h00;
  assign busy       = busy_state || (state == ST_HASH);

endmodule

// File: tb/tb_thiele_exec_core.sv
// Directed bench for thiele_exec_core: short programs with hand-computed counters and hashes,
// EMIT backpressure, timeout abort and mid-run reset.
module tb_thiele_exec_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         imem_req;
  logic [7:0]   imem_addr;
  logic [31:0]  imem_rdata = 32'd0;
  logic         imem_valid = 1'b0;
  logic         emit_valid;
  logic [7:0]   emit_a, emit_b;
  logic         emit_ready = 1'b0;
  logic         busy, done, timed_out;
  logic [255:0] final_hash;
  logic [63:0]  mu_total;
  logic [31:0]  step_count, pc;

  thiele_exec_core #(.TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .emit_valid (emit_valid),
    .emit_a     (emit_a),
    .emit_b     (emit_b),
    .emit_ready (emit_ready),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .final_hash (final_hash),
    .mu_total   (mu_total),
    .step_count (step_count),
    .pc         (pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // hand-computed hashes (mix(3)=000C6063, mix(4)=00108084, mix(6)=0018C0C6,
  // mix(1)=00042021, mix(2)=00084042, mix(5)=0014A0A5, mix(24h)=009484E6)
  localparam logic [255:0] H_PROG1 =
    256'h000C6063_0018C0C6_00000000_00000000_00108084_00108084_000C6063_000C6063;
  localparam logic [255:0] H_PROG2 =
    256'h00000000_00000000_00000000_009484E6_00108084_00000000_00084042_00042021;
  localparam logic [255:0] H_NOOPS =
    256'h00000000_00000000_00000000_00000000_00042021_00042021_0014A0A5_0014A0A5;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  logic        sb_en = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // instruction memory responder
  logic [31:0] prog [256];
  int imem_lat = 1;
  int lat_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_valid = 1'b0;
        lat_cnt    = 0;
      end else if (imem_valid) begin
        imem_valid = 1'b0;
      end else if (imem_req) begin
        lat_cnt++;
        if (lat_cnt >= imem_lat) begin
          imem_rdata = prog[imem_addr];
          imem_valid = 1'b1;
          lat_cnt    = 0;
        end
      end
    end
  end

  // emit scoreboard
  initial begin
    logic [15:0] exp_e;
    forever begin
      @(negedge clk);
      #4;
      if (sb_en && rst_n && emit_valid && emit_ready) begin
        check("emit_q_nonempty", 256'(exp_q.size() != 0), 256'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("emit_data", {emit_a, emit_b}, exp_e);
        end
      end
    end
  end

  // driver tasks
  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    return {op, a, b, 8'h00};
  endfunction

  task automatic fill_prog(input logic [31:0] w);
    for (int i = 0; i < 256; i++) prog[i] = w;
  endtask

  task automatic load_prog1();
    fill_prog(32'hFF000000);
    prog[0] = mk(8'h0A, 8'd0, 8'd5);
    prog[1] = mk(8'h0A, 8'd1, 8'd3);
    prog[2] = mk(8'h0B, 8'd0, 8'd1);
    prog[3] = mk(8'hFF, 8'd0, 8'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_emit(input string tag, input int budget);
    int n = 0;
    while (!emit_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, emit_valid, 1'b1);
  endtask

  initial begin
    int nv;
    fill_prog(32'hFF000000);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_emit_valid", emit_valid, 0);
    check("rst_hash", final_hash, 0);
    check("rst_counters", {mu_total, step_count, pc}, 0);
    rst_n = 1'b1;

    // program 1: XOR_LOAD/XOR_ADD
    load_prog1();
    imem_lat = 1;
    pulse_start();
    wait_done("p1_done", 200);
    check("p1_timed_out", timed_out, 0);
    check("p1_busy", busy, 0);
    check("p1_pc", pc, 3);
    check("p1_step", step_count, 3);
    check("p1_mu_total", mu_total, 4);
    check("p1_dmem0", dut.dmem[0], 6);
    check("p1_dmem1", dut.dmem[1], 3);
    check("p1_hash", final_hash, H_PROG1);

    // program 2: PNEW/PMERGE
    fill_prog(32'hFF000000);
    prog[0] = mk(8'h00, 8'd2, 8'd0);
    prog[1] = mk(8'h00, 8'd5, 8'd0);
    prog[2] = mk(8'h02, 8'd0, 8'd1);
    imem_lat = 2;
    pulse_start();
    wait_done("p2_done", 200);
    check("p2_mu_total", mu_total, 4);
    check("p2_step", step_count, 3);
    check("p2_num_modules", dut.u_table.num_modules, 1);
    check("p2_hash", final_hash, H_PROG2);

    // out-of-range PNEW, self-merge, unknown opcode and PSPLIT all retire without mu
    fill_prog(32'hFF000000);
    prog[0] = mk(8'h00, 8'd70, 8'd0);
    prog[1] = mk(8'h02, 8'd0, 8'd0);
    prog[2] = mk(8'h55, 8'd1, 8'd2);
    prog[3] = mk(8'h01, 8'd3, 8'd0);
    imem_lat = 1;
    pulse_start();
    wait_done("nop_done", 200);
    check("nop_mu_total", mu_total, 1);
    check("nop_step", step_count, 4);
    check("nop_pc", pc, 4);
    check("nop_hash", final_hash, H_NOOPS);

    // program 3: XOR_SWAP including a==b
    fill_prog(32'hFF000000);
    prog[0] = mk(8'h0A, 8'd4, 8'd9);
    prog[1] = mk(8'h0C, 8'd4, 8'd4);
    prog[2] = mk(8'h0A, 8'd5, 8'd7);
    prog[3] = mk(8'h0C, 8'd4, 8'd5);
    pulse_start();
    wait_done("p3_done", 200);
    check("p3_dmem4", dut.dmem[4], 7);
    check("p3_dmem5", dut.dmem[5], 0);
    check("p3_mu_total", mu_total, 9);
    check("p3_step", step_count, 4);

    // program 4: EMIT under backpressure
    fill_prog(32'hFF000000);
    prog[0] = mk(8'h0E, 8'd1, 8'd2);
    exp_q.push_back(16'h0102);
    sb_en = 1'b1;
    emit_ready = 1'b0;
    pulse_start();
    wait_emit("p4_emit_seen", 50);
    nv = 0;
    for (int k = 0; k < 20 && emit_valid; k++) begin
      nv++;
      check("p4_emit_a", emit_a, 1);
      check("p4_emit_b", emit_b, 2);
      check("p4_step_hold", step_count, 0);
      if (nv == 6) emit_ready = 1'b1;
      @(negedge clk);
    end
    emit_ready = 1'b0;
    check("p4_valid_cycles", nv, 6);
    check("p4_step_after", step_count, 1);
    wait_done("p4_done", 200);
    sb_en = 1'b0;
    check("p4_sb_empty", exp_q.size(), 0);
    check("p4_pc", pc, 1);
    check("p4_mu_total", mu_total, 1);

    // program 5: endless EMIT stream hits the 64-cycle timeout
    fill_prog(mk(8'h0E, 8'd0, 8'd0));
    emit_ready = 1'b1;
    pulse_start();
    repeat (63) @(negedge clk);
    check("p5_busy_63", busy, 1);
    check("p5_done_63", done, 0);
    @(negedge clk);
    check("p5_done_64", done, 1);
    check("p5_timed_out", timed_out, 1);
    check("p5_busy_64", busy, 0);
    check("p5_hash_zero", final_hash, 0);
    emit_ready = 1'b0;

    // program 6: reset during EMIT_WAIT, then program 1 with slow imem
    fill_prog(32'hFF000000);
    prog[0] = mk(8'h0A, 8'd0, 8'd1);
    prog[1] = mk(8'h0E, 8'd7, 8'd7);
    imem_lat = 3;
    pulse_start();
    wait_emit("p6_emit_seen", 100);
    check("p6_pre_step", step_count, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("p6_rst_busy", busy, 0);
    check("p6_rst_done", {done, timed_out}, 0);
    check("p6_rst_emit", {emit_valid, emit_a, emit_b, imem_req}, 0);
    check("p6_rst_counters", {mu_total, step_count, pc}, 0);
    check("p6_rst_hash", final_hash, 0);
    load_prog1();
    pulse_start();
    wait_done("p6_done", 300);
    check("p6_timed_out", timed_out, 0);
    check("p6_counters", {mu_total, step_count, pc}, {64'd4, 32'd3, 32'd3});
    check("p6_hash", final_hash, H_PROG1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
